crc_stream_par: RTL and testbench

Parametrised parallel CRC engine, successor to the fixed 5-bit/16-bit CRC block. It folds one DATA_W-bit word per cycle into a running CRC and accumulates multi-word frames delimited by sof/eof. It has valid/ready handshakes on the input and the result. Parametrisable generator, init and final XOR allow one RTL to serve CRC-5/8/16/32 users in the pipeline.

---
 rtl/crc_stream_par.sv | 101 ++++++++++
 tb/tb_crc_stream_par.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_par.sv
// rtl/crc_stream_par.sv - parametrised parallel CRC engine with sof/eof framed word input
// One DATA_W-bit word folded per cycle; finished frame CRC offered on a valid/ready result port.
module crc_stream_par #(
   parameter int                 CRC_W   = 5,
   parameter int                 DATA_W  = 16,
   parameter logic [CRC_W-1:0]   POLY    = 5'h05,
   parameter logic [CRC_W-1:0]   INIT    = '0,
   parameter logic [CRC_W-1:0]   XOR_OUT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sof,
   input  logic              in_eof,
   output logic              crc_valid,
   input  logic              crc_ready,
   output logic [CRC_W-1:0]  crc_out,
   output logic              frm_err
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OPEN = 1'b1
   } fsm_t;

   fsm_t             fsm;
   fsm_t             fsm_next;
   logic [CRC_W-1:0] state;
   logic [CRC_W-1:0] seed;
   logic [CRC_W-1:0] next_state;
   logic             accept;
   logic             take;
   logic             finish;
   logic             err_now;

   // MSB of the word is the first bit on the wire, so it is folded first.
   function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] s_in,
                                             input logic [DATA_W-1:0] d);
      logic [CRC_W-1:0] s;
      logic             fb;
      s = s_in;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb = s[CRC_W-1] ^ d[i];
         s  = {s[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return s;
   endfunction

   // Input stalls whenever an unconsumed result would be overwritten.
   assign in_ready   = !(crc_valid && !crc_ready);
   assign accept     = in_valid && in_ready;
   assign seed       = in_sof ? INIT : state;
   assign next_state = fold(seed, in_data);

   always_comb begin
      fsm_next = fsm;
      take     = 1'b0;
      err_now  = 1'b0;
      finish   = 1'b0;
      if (accept) begin
         if (in_sof) begin
            take    = 1'b1;
            err_now = (fsm == S_OPEN);
         end else if (fsm == S_OPEN) begin
            take = 1'b1;
         end else begin
            err_now = 1'b1;
         end
         if (take) begin
            finish   = in_eof;
            fsm_next = in_eof ? S_IDLE : S_OPEN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm       <= S_IDLE;
         state     <= INIT;
         crc_valid <= 1'b0;
         crc_out   <= '0;
         frm_err   <= 1'b0;
      end else begin
         fsm     <= fsm_next;
         frm_err <= err_now;
         if (take) begin
            state <= finish ? INIT : next_state;
         end
         // A new eof wins over consumption so single-word frames stream at full rate.
         if (finish) begin
            crc_out   <= next_state ^ XOR_OUT;
            crc_valid <= 1'b1;
         end else if (crc_valid && crc_ready) begin
            crc_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crc_stream_par.sv
// tb/tb_crc_stream_par.sv - self-checking bench for crc_stream_par
// Frame-level reference model plus directed vectors with literal expectations.
module tb_crc_stream_par;

   localparam int          CRC_W   = 5;
   localparam int          DATA_W  = 16;
   localparam logic [4:0]  POLY    = 5'h05;
   localparam logic [4:0]  XOR_OUT = 5'h00;
   localparam logic [4:0]  XOR_X   = 5'h1F;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [7:0]  d8 = '0;
   logic        in_sof = 1'b0;
   logic        in_eof = 1'b0;
   logic        crc_valid;
   logic        crc_ready = 1'b1;
   logic [4:0]  crc_out;
   logic        frm_err;

   logic        x_in_ready, x_crc_valid, x_frm_err;
   logic [4:0]  x_crc_out;
   logic        b_in_ready, b_crc_valid, b_frm_err;
   logic [7:0]  b_crc_out;

   int checks = 0;
   int errors = 0;

   crc_stream_par dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
      .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_out(crc_out), .frm_err(frm_err)
   );

   crc_stream_par #(.XOR_OUT(5'h1F)) dut_x (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready),
      .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
      .crc_valid(x_crc_valid), .crc_ready(crc_ready), .crc_out(x_crc_out), .frm_err(x_frm_err)
   );

   crc_stream_par #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(d8), .in_sof(in_sof), .in_eof(in_eof),
      .crc_valid(b_crc_valid), .crc_ready(crc_ready), .crc_out(b_crc_out), .frm_err(b_frm_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remainder of the whole frame bit sequence by long division.
   bit         frame_q[$];
   logic       exp_valid = 1'b0;
   logic       exp_err   = 1'b0;
   logic       exp_open  = 1'b0;
   logic [4:0] exp_out   = '0;
   logic [4:0] exp_out_x = '0;

   function automatic logic [4:0] crc_ref();
      logic [5:0] r;
      int         n;
      bit         b;
      r = '0;
      n = frame_q.size();
      for (int i = 0; i < n + CRC_W; i++) begin
         b = (i < n) ? frame_q[i] : 1'b0;
         r = {r[4:0], b};
         if (r[5]) r = r ^ {1'b1, POLY};
      end
      return r[4:0];
   endfunction

   always @(posedge clk) begin
      logic acc, take, fin, new_err;
      acc     = in_valid && !(exp_valid && !crc_ready);
      take    = 1'b0;
      fin     = 1'b0;
      new_err = 1'b0;
      if (!rst) begin
         exp_valid = 1'b0;
         exp_err   = 1'b0;
         exp_open  = 1'b0;
         exp_out   = '0;
         exp_out_x = '0;
         frame_q.delete();
      end else begin
         if (acc) begin
            if (in_sof) begin
               new_err = exp_open;
               frame_q.delete();
               take = 1'b1;
            end else if (exp_open) begin
               take = 1'b1;
            end else begin
               new_err = 1'b1;
            end
            if (take) begin
               for (int i = DATA_W - 1; i >= 0; i--) frame_q.push_back(in_data[i]);
               if (in_eof) begin
                  exp_out   = crc_ref() ^ XOR_OUT;
                  exp_out_x = crc_ref() ^ XOR_X;
                  fin       = 1'b1;
                  exp_open  = 1'b0;
                  frame_q.delete();
               end else begin
                  exp_open = 1'b1;
               end
            end
         end
         if (fin) exp_valid = 1'b1;
         else if (exp_valid && crc_ready) exp_valid = 1'b0;
         exp_err = new_err;
      end
   end

   always @(negedge clk) begin
      check("m_crc_valid", 32'(crc_valid), 32'(exp_valid));
      check("m_in_ready", 32'(in_ready), 32'(!(exp_valid && !crc_ready)));
      check("m_frm_err", 32'(frm_err), 32'(exp_err));
      check("m_crc_out", 32'(crc_out), 32'(exp_out));
      check("m_crc_out_xor", 32'(x_crc_out), 32'(exp_out_x));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
   endtask

   task automatic send(input logic [15:0] d, input logic sof, input logic eof);
      in_valid = 1'b1;
      in_data  = d;
      d8       = d[7:0];
      in_sof   = sof;
      in_eof   = eof;
      step();
      idle();
   endtask

   logic [15:0] b2b_d [3] = '{16'h0001, 16'h8000, 16'h911C};
   logic [4:0]  b2b_c [3] = '{5'h05, 5'h0C, 5'h00};

   initial begin
      rst = 1'b0;
      step();
      step();
      check("rst_crc_valid", 32'(crc_valid), 32'd0);
      check("rst_crc_out", 32'(crc_out), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_frm_err", 32'(frm_err), 32'd0);
      rst = 1'b1;
      step();

      send(16'h911C, 1'b1, 1'b1);
      check("codeword_valid", 32'(crc_valid), 32'd1);
      check("codeword_crc", 32'(crc_out), 32'h00);
      step();
      send(16'h0001, 1'b1, 1'b1);
      check("w0001_crc", 32'(crc_out), 32'h05);
      check("w0001_xor_crc", 32'(x_crc_out), 32'h1A);
      check("w01_crc8", 32'(b_crc_out), 32'h07);
      step();
      send(16'h8000, 1'b1, 1'b1);
      check("w8000_crc", 32'(crc_out), 32'h0C);
      step();

      send(16'h0001, 1'b1, 1'b0);
      check("two_word_mid_valid", 32'(crc_valid), 32'd0);
      send(16'h0000, 1'b0, 1'b1);
      check("two_word_crc", 32'(crc_out), 32'h18);
      step();
      send(16'h0000, 1'b1, 1'b0);
      send(16'h0001, 1'b0, 1'b1);
      check("two_word_rev_crc", 32'(crc_out), 32'h05);
      step();

      crc_ready = 1'b0;
      send(16'h0001, 1'b1, 1'b1);
      check("bp_first_crc", 32'(crc_out), 32'h05);
      in_valid = 1'b1;
      in_data  = 16'h8000;
      d8       = 8'h00;
      in_sof   = 1'b1;
      in_eof   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_valid", 32'(crc_valid), 32'd1);
         check("bp_hold_crc", 32'(crc_out), 32'h05);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      crc_ready = 1'b1;
      step();
      idle();
      check("bp_release_valid", 32'(crc_valid), 32'd1);
      check("bp_release_crc", 32'(crc_out), 32'h0C);
      step();

      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = b2b_d[i];
         in_sof   = 1'b1;
         in_eof   = 1'b1;
         step();
         check("b2b_valid", 32'(crc_valid), 32'd1);
         check("b2b_crc", 32'(crc_out), 32'(b2b_c[i]));
      end
      idle();
      step();

      send(16'h1234, 1'b0, 1'b0);
      check("orphan_frm_err", 32'(frm_err), 32'd1);
      check("orphan_no_valid", 32'(crc_valid), 32'd0);
      step();
      check("orphan_err_pulse_end", 32'(frm_err), 32'd0);

      send(16'h8000, 1'b1, 1'b0);
      send(16'h0001, 1'b1, 1'b0);
      check("resof_frm_err", 32'(frm_err), 32'd1);
      send(16'h0000, 1'b0, 1'b1);
      check("resof_crc", 32'(crc_out), 32'h18);
      check("resof_err_cleared", 32'(frm_err), 32'd0);
      step();

      send(16'h0001, 1'b1, 1'b0);
      rst = 1'b0;
      step();
      check("midrst_crc_out", 32'(crc_out), 32'd0);
      check("midrst_valid", 32'(crc_valid), 32'd0);
      rst = 1'b1;
      send(16'h0001, 1'b1, 1'b1);
      check("after_rst_crc", 32'(crc_out), 32'h05);
      check("after_rst_valid", 32'(crc_valid), 32'd1);
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
